demux_1to4_stream: RTL and testbench
====================================

DEMUX_1TO4_STREAM -- requirements
Module: demux_1to4_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in  input  WIDTH  input data word.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-007 SHALL have port s  input  2  destination lane select, sampled with in/in_valid.
REQ-008 SHALL have port enable  input  1  1 = routing allowed, 0 = input stalled.
REQ-009 SHALL have port out  output  4*WIDTH  lane i data at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid  output  4  per-lane data-held flag.
REQ-011 SHALL have port out_ready  input  4  per-lane downstream ready.
REQ-012 SHALL have port cnt  output  32  per-lane delivered count, lane i at bits [i*8 +: 8].

Function
REQ-013 SHALL hold one single-entry register per lane (data + valid); no other data storage.
REQ-014 SHALL drive in_ready = enable AND (NOT out_valid[s] OR out_ready[s]), combinationally.
REQ-015 SHALL accept a word when in_valid AND in_ready at a rising edge: lane s data <= in, out_valid[s] <= 1.
REQ-016 SHALL present an accepted word on its lane one cycle after acceptance (latency 1); no combinational path from in/in_valid to out/out_valid.
REQ-017 SHALL complete a lane transfer when out_valid[i] AND out_ready[i] at a rising edge; out_valid[i] clears unless the same edge also accepts a word for lane i.
REQ-018 SHALL, on simultaneous drain and reload of lane i, keep out_valid[i]=1 and load the new word (full throughput, one word/cycle per lane).
REQ-019 SHALL hold lane i data stable while out_valid[i]=1 and out_ready[i]=0.
REQ-020 SHALL leave unselected lanes' data, valid and counters unaffected by an accept.
REQ-021 SHALL allow out_ready on any lane to drain independently of s, enable and in_valid.
REQ-022 SHALL, when enable=0, accept nothing (in_ready=0) while held lane words continue to drain.
REQ-023 SHALL allow s to change every cycle; ordering guaranteed only within a lane.
REQ-024 SHALL increment cnt lane i by 1 on each lane-i transfer (REQ-017), wrapping 255 -> 0.
REQ-025 SHALL not change out_valid/out lanes when in_valid=1 but in_ready=0 (word stays upstream).
REQ-026 SHALL treat out data of a lane with out_valid=0 as don't-care to consumers, but SHALL not change it except on accept or reset.

Reset
REQ-027 SHALL, while rst_n=0, force out_valid=4'b0000, out=0, cnt=0 immediately, independent of clk.
REQ-028 SHALL drive in_ready per REQ-014 during reset (out_valid=0, so in_ready = enable) but SHALL not capture any word while rst_n=0.
REQ-029 SHALL discard held words on reset asserted mid-operation; no partial transfer completes.
REQ-030 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-031 Reset: rst_n=0 mid-run with out_valid=4'b1010 -> out_valid=0, out=0, cnt=0 without waiting for clk.
REQ-032 Routing: enable=1, out_ready=4'b0000, send 8'hA1,s=0 / 8'hB2,s=1 / 8'hC3,s=2 / 8'hD4,s=3 -> out=32'hD4C3B2A1, out_valid=4'b1111, in_ready=0 for any s afterwards.
REQ-033 Backpressure: lane 2 full, out_ready[2]=0, in=8'h55,s=2,in_valid=1 for 5 cycles -> in_ready=0, lane 2 holds old word; raise out_ready[2] -> same edge drains old word and loads 8'h55, out_valid[2] stays 1.
REQ-034 Throughput: out_ready=4'b1111, 10 back-to-back words to s=1 -> in_ready=1 every cycle, each word on lane 1 one cycle later, cnt lane 1 = 10.
REQ-035 Enable: enable=0 with lane 0 full, out_ready[0]=1 -> lane 0 drains, cnt lane 0 +1, in_ready=0, no new accepts.
REQ-036 Wrap: 256 transfers on lane 3 -> cnt lane 3 returns to 8'h00; other lanes' counts unchanged.

Source files
------------

// File: rtl/demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to4_stream
// Description : 1-to-4 valid/ready stream demultiplexer, one register slice
//               per lane with a per-lane delivered-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1to4_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         s,
  input  logic               enable,
  output logic [4*WIDTH-1:0] out,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [31:0]        cnt
);

  localparam int c_LANES = 4;

  logic w_in_ready;
  logic w_accept;

  // A full lane can still take a word on the cycle it is being drained.
  assign w_in_ready = enable & (~out_valid[s] | out_ready[s]);
  assign in_ready   = w_in_ready;
  assign w_accept   = in_valid & w_in_ready;

  for (genvar i = 0; i < c_LANES; i++) begin : g_lane
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [7:0]       r_cnt;
    logic             w_load;
    logic             w_drain;

    assign w_load  = w_accept & (s == 2'(i));
    assign w_drain = r_valid & out_ready[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
        r_cnt   <= 8'd0;
      end else begin
        if (w_load) begin
          r_data  <= in;
          r_valid <= 1'b1;
        end else if (w_drain) begin
          r_valid <= 1'b0;
        end
        if (w_drain) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end

    assign out[i*WIDTH +: WIDTH] = r_data;
    assign out_valid[i]          = r_valid;
    assign cnt[i*8 +: 8]         = r_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1to4_stream
// Description : Scoreboard bench for demux_1to4_stream with directed and
//               random traffic against per-lane FIFO reference queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1to4_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        in_ready;
  logic [1:0]  s;
  logic        enable;
  logic [31:0] out;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] cnt;

  int checks = 0;
  int errors = 0;

  // Reference: each lane is a queue of accepted-but-undelivered words.
  logic [7:0] sb [4][$];
  logic [7:0] cnt_model [4];

  always #5 clk = ~clk;

  demux_1to4_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (din),
    .in_valid  (din_valid),
    .in_ready  (in_ready),
    .s         (s),
    .enable    (enable),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt       (cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      sb[i].delete();
      cnt_model[i] = 8'd0;
    end
  endtask

  // Drive one cycle of inputs; they are consumed by the following rising edge.
  task automatic step(input logic [7:0] d, input logic v, input logic [1:0] sel,
                      input logic en, input logic [3:0] ordy);
    logic exp_rdy;
    @(posedge clk);
    #1;
    din = d; din_valid = v; s = sel; enable = en; out_ready = ordy;
    #3;
    exp_rdy = en && ((sb[sel].size() == 0) || ordy[sel]);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    #2;
    if (v && exp_rdy) sb[sel].push_back(d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    clear_model();
    #4;
    chk("rst_in_ready", {31'd0, in_ready}, {31'd0, enable});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares lane state against the reference and retires words
  // that the next rising edge delivers.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("out_valid[%0d]", i), {31'd0, out_valid[i]},
            {31'd0, (sb[i].size() != 0)});
        chk($sformatf("cnt[%0d]", i), {24'd0, cnt[i*8 +: 8]}, {24'd0, cnt_model[i]});
        if (sb[i].size() != 0) begin
          chk($sformatf("data[%0d]", i), {24'd0, out[i*8 +: 8]}, {24'd0, sb[i][0]});
          if (out_ready[i]) begin
            void'(sb[i].pop_front());
            cnt_model[i] = cnt_model[i] + 8'd1;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; din = 8'd0; din_valid = 1'b0; s = 2'd0; enable = 1'b1; out_ready = 4'd0;
    clear_model();
    repeat (2) @(posedge clk);
    #3;
    chk("init_out_valid", {28'd0, out_valid}, 32'd0);
    chk("init_cnt", cnt, 32'd0);
    chk("init_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Asynchronous reset with lanes 1 and 3 holding words
    step(8'h11, 1'b1, 2'd1, 1'b1, 4'b0000);
    step(8'h33, 1'b1, 2'd3, 1'b1, 4'b0000);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b0000);
    chk("pre_rst_valid", {28'd0, out_valid}, 32'h0000_000A);
    do_reset();

    // Routing to all four lanes with downstream stalled
    step(8'hA1, 1'b1, 2'd0, 1'b1, 4'b0000);
    step(8'hB2, 1'b1, 2'd1, 1'b1, 4'b0000);
    step(8'hC3, 1'b1, 2'd2, 1'b1, 4'b0000);
    step(8'hD4, 1'b1, 2'd3, 1'b1, 4'b0000);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b0000);
    chk("route_out", out, 32'hD4C3_B2A1);
    chk("route_valid", {28'd0, out_valid}, 32'h0000_000F);
    for (int k = 0; k < 4; k++) step(8'hEE, 1'b1, 2'(k), 1'b1, 4'b0000);

    // Backpressure on lane 2, then simultaneous drain and reload
    repeat (5) step(8'h55, 1'b1, 2'd2, 1'b1, 4'b0000);
    chk("bp_hold", {24'd0, out[23:16]}, 32'h0000_00C3);
    step(8'h55, 1'b1, 2'd2, 1'b1, 4'b0100);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b0000);
    chk("bp_reload", {24'd0, out[23:16]}, 32'h0000_0055);
    chk("bp_valid2", {31'd0, out_valid[2]}, 32'd1);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b1111);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b1111);

    // Full throughput on lane 1
    do_reset();
    for (int k = 0; k < 10; k++) step(8'($urandom), 1'b1, 2'd1, 1'b1, 4'b1111);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b1111);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b1111);
    chk("tput_cnt1", {24'd0, cnt[15:8]}, 32'd10);

    // Enable low: lane 0 drains, nothing accepted
    do_reset();
    step(8'h77, 1'b1, 2'd0, 1'b1, 4'b0000);
    step(8'h99, 1'b1, 2'd0, 1'b0, 4'b0001);
    step(8'h99, 1'b1, 2'd0, 1'b0, 4'b0001);
    chk("en_cnt0", {24'd0, cnt[7:0]}, 32'd1);
    chk("en_valid", {28'd0, out_valid}, 32'd0);

    // Counter wrap on lane 3
    do_reset();
    for (int k = 0; k < 256; k++) step(8'($urandom), 1'b1, 2'd3, 1'b1, 4'b1111);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b1111);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b1111);
    chk("wrap_cnt", cnt, 32'd0);
    step(8'h42, 1'b1, 2'd3, 1'b1, 4'b1111);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b1111);
    step(8'h00, 1'b0, 2'd0, 1'b1, 4'b1111);
    chk("wrap_cnt_next", cnt, 32'h0100_0000);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      step(8'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) != 0), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
